tree_out_filter: RTL and testbench



---
 rtl/tree_out_filter.sv | 169 ++++++++++++++++
 tb/tb_tree_out_filter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tree_out_filter.sv
// tree_out_filter: synchronises and glitch-filters the logic-tree output y = ~((~a & ~b) | (c & d)).
// Commits after STABLE_CYCLES samples; input is sampled every cycle with no backpressure. TREE_OUT_FILTER_SYNC_EN adds the 2-flop synchroniser.
module tree_out_filter #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             y_in,
   input  logic             clr,
   output logic             y_filt,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic [CNT_W-1:0] rise_cnt,
   output logic [CNT_W-1:0] fall_cnt,
   output logic             busy
);

   localparam int PW = $clog2(STABLE_CYCLES + 1);
   localparam logic [PW-1:0] PEND_LAST = PW'(STABLE_CYCLES);

   typedef enum logic [1:0] {
      LOW_STABLE,
      LOW_PEND,
      HIGH_STABLE,
      HIGH_PEND
   } state_t;

   generate
      if (STABLE_CYCLES < 1) begin : g_bad_param
         $error("tree_out_filter: STABLE_CYCLES must be >= 1");
      end
   endgenerate

   logic sample;

`ifdef TREE_OUT_FILTER_SYNC_EN
   logic s1;
   logic s2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= y_in;
         s2 <= s1;
      end
   end

   assign sample = s2;
`else
   assign sample = y_in;
`endif

   state_t          state_q;
   state_t          state_d;
   logic [PW-1:0]   pend_q;
   logic [PW-1:0]   pend_d;
   logic [PW-1:0]   pend_inc;
   logic            commit_rise;
   logic            commit_fall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LOW_STABLE;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
      end
   end

   assign pend_inc = pend_q + PW'(1);

   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      commit_rise = 1'b0;
      commit_fall = 1'b0;
      case (state_q)
         LOW_STABLE: begin
            if (sample) begin
               if (STABLE_CYCLES == 1) begin
                  state_d     = HIGH_STABLE;
                  commit_rise = 1'b1;
               end else begin
                  state_d = LOW_PEND;
                  pend_d  = PW'(1);
               end
            end
         end
         LOW_PEND: begin
            if (!sample) begin
               // run ended before it was long enough: drop it silently
               state_d = LOW_STABLE;
               pend_d  = '0;
            end else if (pend_inc == PEND_LAST) begin
               state_d     = HIGH_STABLE;
               pend_d      = '0;
               commit_rise = 1'b1;
            end else begin
               pend_d = pend_inc;
            end
         end
         HIGH_STABLE: begin
            if (!sample) begin
               if (STABLE_CYCLES == 1) begin
                  state_d     = LOW_STABLE;
                  commit_fall = 1'b1;
               end else begin
                  state_d = HIGH_PEND;
                  pend_d  = PW'(1);
               end
            end
         end
         HIGH_PEND: begin
            if (sample) begin
               state_d = HIGH_STABLE;
               pend_d  = '0;
            end else if (pend_inc == PEND_LAST) begin
               state_d     = LOW_STABLE;
               pend_d      = '0;
               commit_fall = 1'b1;
            end else begin
               pend_d = pend_inc;
            end
         end
         default: begin
            state_d = LOW_STABLE;
            pend_d  = '0;
         end
      endcase
   end

   // Outputs are flopped from the next-state decode so they line up with state_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_filt     <= 1'b0;
         busy       <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
      end else begin
         y_filt     <= (state_d == HIGH_STABLE) || (state_d == HIGH_PEND);
         busy       <= (state_d == LOW_PEND) || (state_d == HIGH_PEND);
         rise_pulse <= commit_rise;
         fall_pulse <= commit_fall;
      end
   end

   // clr takes priority over a coincident commit; counters stick at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rise_cnt <= '0;
         fall_cnt <= '0;
      end else if (clr) begin
         rise_cnt <= '0;
         fall_cnt <= '0;
      end else begin
         if (commit_rise && (rise_cnt != {CNT_W{1'b1}})) begin
            rise_cnt <= rise_cnt + CNT_W'(1);
         end
         if (commit_fall && (fall_cnt != {CNT_W{1'b1}})) begin
            fall_cnt <= fall_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_tree_out_filter.sv
// Bench for tree_out_filter: STABLE_CYCLES=4/CNT_W=2 instance plus a STABLE_CYCLES=1 instance, scoreboarded pulses.
module tb_tree_out_filter;

`ifdef TREE_OUT_FILTER_SYNC_EN
   localparam int LAT_A  = 6;
   localparam int BUSY_A = 3;
   localparam int LAT_B  = 3;
`else
   localparam int LAT_A  = 4;
   localparam int BUSY_A = 1;
   localparam int LAT_B  = 1;
`endif
   localparam int MAX_A = 3;

   typedef struct {
      logic rise;
      int   cyc;
      int   cnt;
   } ev_t;

   logic       clk;
   logic       rst_n;
   logic       y_a, clr_a, y_b, clr_b;
   logic       a_yf, a_rise, a_fall, a_busy;
   logic [1:0] a_rc, a_fc;
   logic       b_yf, b_rise, b_fall, b_busy;
   logic [7:0] b_rc, b_fc;

   int  cyc = 0;
   int  n_pass = 0;
   int  n_total = 0;
   int  mr = 0;
   int  mf = 0;
   ev_t q_a[$];
   ev_t q_b[$];

   tree_out_filter #(.STABLE_CYCLES(4), .CNT_W(2)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .y_in(y_a), .clr(clr_a),
      .y_filt(a_yf), .rise_pulse(a_rise), .fall_pulse(a_fall),
      .rise_cnt(a_rc), .fall_cnt(a_fc), .busy(a_busy)
   );

   tree_out_filter #(.STABLE_CYCLES(1), .CNT_W(8)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .y_in(y_b), .clr(clr_b),
      .y_filt(b_yf), .rise_pulse(b_rise), .fall_pulse(b_fall),
      .rise_cnt(b_rc), .fall_cnt(b_fc), .busy(b_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic mon_a();
      ev_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (a_rise || a_fall) begin
               n_total++;
               if (q_a.size() == 0) begin
                  $display("FAIL pulse_a_unexpected cyc=%0d rise=%b fall=%b", cyc, a_rise, a_fall);
               end else begin
                  e = q_a.pop_front();
                  if ({a_rise, a_fall, a_yf} !== {e.rise, ~e.rise, e.rise} || cyc != e.cyc ||
                      int'(a_rise ? a_rc : a_fc) != e.cnt) begin
                     $display("FAIL pulse_a cyc=%0d rise=%b fall=%b yf=%b cnt=%0d/%0d, want rise=%b cyc=%0d cnt=%0d",
                              cyc, a_rise, a_fall, a_yf, a_rc, a_fc, e.rise, e.cyc, e.cnt);
                  end else begin
                     n_pass++;
                  end
               end
            end else if (q_a.size() > 0 && q_a[0].cyc < cyc) begin
               e = q_a.pop_front();
               n_total++;
               $display("FAIL pulse_a_missed cyc=%0d want rise=%b at cyc=%0d", cyc, e.rise, e.cyc);
            end
         end
      end
   endtask

   task automatic mon_b();
      ev_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (b_rise || b_fall) begin
               n_total++;
               if (q_b.size() == 0) begin
                  $display("FAIL pulse_b_unexpected cyc=%0d rise=%b fall=%b", cyc, b_rise, b_fall);
               end else begin
                  e = q_b.pop_front();
                  if ({b_rise, b_fall, b_yf} !== {e.rise, ~e.rise, e.rise} || cyc != e.cyc ||
                      int'(b_rise ? b_rc : b_fc) != e.cnt) begin
                     $display("FAIL pulse_b cyc=%0d rise=%b fall=%b yf=%b cnt=%0d/%0d, want rise=%b cyc=%0d cnt=%0d",
                              cyc, b_rise, b_fall, b_yf, b_rc, b_fc, e.rise, e.cyc, e.cnt);
                  end else begin
                     n_pass++;
                  end
               end
            end else if (q_b.size() > 0 && q_b[0].cyc < cyc) begin
               e = q_b.pop_front();
               n_total++;
               $display("FAIL pulse_b_missed cyc=%0d want rise=%b at cyc=%0d", cyc, e.rise, e.cyc);
            end
         end
      end
   endtask

   task automatic watchdog();
      #200000;
      $display("FAIL watchdog timeout at cyc=%0d", cyc);
      $fatal(1, "timeout");
   endtask

   // Drive a new held level on instance A and expect its commit.
   task automatic drive_a(input logic v);
      ev_t e;
      e.rise = v;
      e.cyc  = cyc + LAT_A;
      if (v) begin
         mr = (mr == MAX_A) ? MAX_A : mr + 1;
         e.cnt = mr;
      end else begin
         mf = (mf == MAX_A) ? MAX_A : mf + 1;
         e.cnt = mf;
      end
      q_a.push_back(e);
      y_a = v;
      repeat (LAT_A + 1) @(negedge clk);
   endtask

   task automatic test_reset();
      logic seen;
      rst_n = 1'b0;
      y_a = 1'b0; y_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
      repeat (3) @(negedge clk);
      n_total++;
      if ({a_yf, a_rise, a_fall, a_rc, a_fc, a_busy} !== 9'b0) begin
         $display("FAIL reset_a got yf=%b r=%b f=%b rc=%0d fc=%0d busy=%b want all 0",
                  a_yf, a_rise, a_fall, a_rc, a_fc, a_busy);
      end else n_pass++;
      n_total++;
      if ({b_yf, b_rise, b_fall, b_rc, b_fc, b_busy} !== 20'b0) begin
         $display("FAIL reset_b got yf=%b r=%b f=%b rc=%0d fc=%0d busy=%b want all 0",
                  b_yf, b_rise, b_fall, b_rc, b_fc, b_busy);
      end else n_pass++;
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         seen = seen | a_busy | a_yf | b_busy | b_yf;
      end
      n_total++;
      if (seen !== 1'b0 || a_rc !== 2'd0 || a_fc !== 2'd0) begin
         $display("FAIL idle_low got busy/yf_seen=%b rc=%0d fc=%0d want 0 0 0", seen, a_rc, a_fc);
      end else n_pass++;
   endtask

   task automatic test_rise();
      ev_t e;
      int  n;
      n = cyc;
      e.rise = 1'b1; e.cyc = n + LAT_A; e.cnt = 1;
      mr = 1;
      q_a.push_back(e);
      y_a = 1'b1;
      repeat (BUSY_A) @(negedge clk);
      n_total++;
      if (a_busy !== 1'b1 || a_yf !== 1'b0) begin
         $display("FAIL busy_rise cyc=%0d got busy=%b yf=%b want 1 0", cyc, a_busy, a_yf);
      end else n_pass++;
      repeat (LAT_A - BUSY_A + 1) @(negedge clk);
      n_total++;
      if ({a_rise, a_yf, a_busy, a_rc} !== {1'b0, 1'b1, 1'b0, 2'd1}) begin
         $display("FAIL after_rise got pulse=%b yf=%b busy=%b rc=%0d want 0 1 0 1", a_rise, a_yf, a_busy, a_rc);
      end else n_pass++;
      drive_a(1'b0);
   endtask

   task automatic test_glitch();
      int   busy_cycles;
      logic yf_seen;
      busy_cycles = 0;
      yf_seen = 1'b0;
      y_a = 1'b1;
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         if (i == 2) y_a = 1'b0;
         if (a_busy) busy_cycles++;
         yf_seen = yf_seen | a_yf;
      end
      n_total++;
      if (busy_cycles != 3 || yf_seen !== 1'b0 || int'(a_rc) != mr) begin
         $display("FAIL glitch got busy_cycles=%0d yf_seen=%b rc=%0d want 3 0 %0d", busy_cycles, yf_seen, a_rc, mr);
      end else n_pass++;
   endtask

   task automatic test_saturation();
      ev_t e;
      for (int i = 0; i < 5; i++) begin
         drive_a(1'b1);
         drive_a(1'b0);
      end
      n_total++;
      if (a_rc !== 2'd3 || a_fc !== 2'd3) begin
         $display("FAIL saturate got rc=%0d fc=%0d want 3 3", a_rc, a_fc);
      end else n_pass++;
      e.rise = 1'b1; e.cyc = cyc + LAT_A; e.cnt = 0;
      q_a.push_back(e);
      mr = 0; mf = 0;
      y_a = 1'b1;
      repeat (LAT_A - 1) @(negedge clk);
      clr_a = 1'b1;
      @(negedge clk);
      clr_a = 1'b0;
      n_total++;
      if (a_rc !== 2'd0 || a_fc !== 2'd0 || a_yf !== 1'b1) begin
         $display("FAIL clr_commit got rc=%0d fc=%0d yf=%b want 0 0 1", a_rc, a_fc, a_yf);
      end else n_pass++;
      @(negedge clk);
      drive_a(1'b0);
   endtask

   task automatic test_reset_mid_pend();
      int n;
      drive_a(1'b1);
      y_a = 1'b0;
      repeat (LAT_A - 2) @(negedge clk);
      n_total++;
      if (a_busy !== 1'b1 || a_yf !== 1'b1) begin
         $display("FAIL high_pend got busy=%b yf=%b want 1 1", a_busy, a_yf);
      end else n_pass++;
      y_a = 1'b1;
      rst_n = 1'b0;
      #1;
      n_total++;
      if ({a_yf, a_rise, a_fall, a_rc, a_fc, a_busy} !== 9'b0) begin
         $display("FAIL async_reset got yf=%b r=%b f=%b rc=%0d fc=%0d busy=%b want all 0",
                  a_yf, a_rise, a_fall, a_rc, a_fc, a_busy);
      end else n_pass++;
      mr = 0; mf = 0;
      repeat (3) @(negedge clk);
      n = cyc;
      rst_n = 1'b1;
      begin
         ev_t e;
         e.rise = 1'b1; e.cyc = n + LAT_A; e.cnt = 1;
         q_a.push_back(e);
         mr = 1;
      end
      repeat (LAT_A + 3) @(negedge clk);
      n_total++;
      if (a_rc !== 2'd1 || a_yf !== 1'b1 || a_busy !== 1'b0 || a_fc !== 2'd0) begin
         $display("FAIL release_high got rc=%0d fc=%0d yf=%b busy=%b want 1 0 1 0", a_rc, a_fc, a_yf, a_busy);
      end else n_pass++;
   endtask

   task automatic test_single_pulse();
      ev_t e;
      e.rise = 1'b1; e.cyc = cyc + LAT_B; e.cnt = 1;
      q_b.push_back(e);
      e.rise = 1'b0; e.cyc = cyc + LAT_B + 1; e.cnt = 1;
      q_b.push_back(e);
      y_b = 1'b1;
      @(negedge clk);
      y_b = 1'b0;
      repeat (LAT_B + 3) @(negedge clk);
      n_total++;
      if (b_rc !== 8'd1 || b_fc !== 8'd1 || b_yf !== 1'b0 || b_busy !== 1'b0) begin
         $display("FAIL single_pulse got rc=%0d fc=%0d yf=%b busy=%b want 1 1 0 0", b_rc, b_fc, b_yf, b_busy);
      end else n_pass++;
   endtask

   initial begin
      rst_n = 1'b0;
      y_a = 1'b0; y_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
      fork
         mon_a();
         mon_b();
         watchdog();
      join_none
      test_reset();
      test_rise();
      test_glitch();
      test_saturation();
      test_reset_mid_pend();
      test_single_pulse();
      repeat (5) @(negedge clk);
      n_total++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         $display("FAIL scoreboard_drain got pending a=%0d b=%0d want 0 0", q_a.size(), q_b.size());
      end else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
